// File: rtl/ser_word_sched.sv
// Round-robin scheduler feeding one 32-to-8 serializer. A grant appears 1 cycle after the request and holds for 4 byte cycles.
// There is no backpressure: the owning lane is popped on the last byte, and req/lane_en changes take effect only at word boundaries.
module ser_word_sched #(
  parameter int LANES = 4,
  localparam int LW = $clog2(LANES)
) (
  input  logic                clk_4f,
  input  logic                reset,
  input  logic [LANES-1:0]    req,
  input  logic [32*LANES-1:0] lane_data,
  input  logic [LANES-1:0]    lane_en,
  output logic [31:0]         word_out,
  output logic                word_valid,
  output logic [LW-1:0]       lane_id,
  output logic [1:0]          byte_idx,
  output logic [LANES-1:0]    pop,
  output logic                busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    last;
  logic [LW-1:0]    win;
  logic             win_vld;
  logic             load;
  logic             word_end;
  logic [LANES-1:0] cand;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    word_end = (state == SEND) && (byte_idx == 2'd3);

    // The lane being popped still shows req for the word just consumed.
    cand = req & lane_en;
    for (int j = 0; j < LANES; j++) begin
      if (word_end && (int'(lane_id) == j)) cand[j] = 1'b0;
    end

    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= LANES; k++) begin
      for (int j = 0; j < LANES; j++) begin
        if (!win_vld && cand[j] && (j == (int'(last) + k) % LANES)) begin
          win_vld = 1'b1;
          win     = LW'(j);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = SEND;
          load      = 1'b1;
        end
      end
      SEND: begin
        if (word_end) begin
          for (int j = 0; j < LANES; j++) pop[j] = (int'(lane_id) == j);
          if (win_vld) load      = 1'b1;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign word_valid = (state == SEND);
  assign busy       = word_valid;

  // byte_idx wraps 3->0 on its own, so returning to IDLE leaves it at 0.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      word_out <= '0;
      lane_id  <= '0;
      byte_idx <= '0;
      last     <= LW'(LANES - 1);
    end else if (load) begin
      word_out <= lane_data[{win, 5'd0} +: 32];
      lane_id  <= win;
      last     <= win;
      byte_idx <= 2'd0;
    end else if (state == SEND) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule
